// File: rtl/remote_pkg.sv
// remote_pkg: types and constants shared by the RemoteComm path.
// Holds the ACK byte, the arbiter state enum and the command slot word.
package remote_pkg;

  localparam logic [7:0] ACK_POS = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    SEND,
    WAIT_SENT,
    WAIT_RESP,
    DONE
  } arb_state_t;

  typedef struct packed {
    logic [7:0]  cmd;
    logic [15:0] data;
  } cmd_word_t;

endpackage

// File: rtl/req_slot.sv
// req_slot: one-deep holding register for a single command requester.
// Ports: i_req/i_word load when empty, i_clr frees, o_word/o_pending/o_rdy.
module req_slot
  import remote_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      i_req,
  input  logic      i_clr,
  input  cmd_word_t i_word,
  output cmd_word_t o_word,
  output logic      o_pending,
  output logic      o_rdy
);

  logic      r_pending;
  cmd_word_t r_word;

  // i_clr only fires while pending, so a same-cycle req is dropped.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pending <= 1'b0;
      r_word    <= '0;
    end else if (i_clr) begin
      r_pending <= 1'b0;
    end else if (i_req && !r_pending) begin
      r_pending <= 1'b1;
      r_word    <= i_word;
    end
  end

  assign o_word    = r_word;
  assign o_pending = r_pending;
  assign o_rdy     = ~r_pending;

endmodule

// File: rtl/remote_cmd_arbiter.sv
// remote_cmd_arbiter: shares one RemoteComm link between two requesters.
// Ports: req/cmdN/dataN in, rdy/done/result out, RemoteComm handshake.
module remote_cmd_arbiter
  import remote_pkg::*;
#(
  parameter int unsigned       TMO_W       = 20,
  parameter logic [TMO_W-1:0]  TIMEOUT_CYC = 20'd1_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req,
  input  logic [7:0]  cmd0,
  input  logic [7:0]  cmd1,
  input  logic [15:0] data0,
  input  logic [15:0] data1,
  output logic [1:0]  rdy,
  output logic [1:0]  done,
  output logic [7:0]  resp_out,
  output logic        ack_ok,
  output logic        timeout,
  output logic        send_cmd,
  output logic [7:0]  cmd,
  output logic [15:0] data,
  input  logic        cmd_sent,
  input  logic        resp_rdy,
  input  logic [7:0]  resp,
  output logic        clr_resp_rdy
);

  localparam logic [TMO_W-1:0] L_LAST = TIMEOUT_CYC - 1'b1;

  arb_state_t       r_state;
  logic             r_owner;
  logic             r_last;
  logic [TMO_W-1:0] r_timer;
  logic [7:0]       r_cmd;
  logic [15:0]      r_data;
  logic             r_send;
  logic             r_clr;
  logic [1:0]       r_done;
  logic [7:0]       r_resp_out;
  logic             r_ack;
  logic             r_tmo;

  cmd_word_t w_in   [2];
  cmd_word_t w_word [2];
  logic [1:0] w_pend;
  logic [1:0] w_rdy;
  logic [1:0] w_clr;
  logic       w_gnt;
  logic [1:0] w_done_vec;

  assign w_in[0] = '{cmd: cmd0, data: data0};
  assign w_in[1] = '{cmd: cmd1, data: data1};

  for (genvar g = 0; g < 2; g++) begin : g_slot
    assign w_clr[g] = (r_state == DONE) && (r_owner == 1'(g));

    req_slot u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .i_req     (req[g]),
      .i_clr     (w_clr[g]),
      .i_word    (w_in[g]),
      .o_word    (w_word[g]),
      .o_pending (w_pend[g]),
      .o_rdy     (w_rdy[g])
    );
  end

  // On a tie the slot not served last wins.
  always_comb begin
    w_gnt = 1'b0;
    unique case (1'b1)
      w_pend[0] && w_pend[1]:  w_gnt = ~r_last;
      w_pend[1] && !w_pend[0]: w_gnt = 1'b1;
      default:                 w_gnt = 1'b0;
    endcase
  end

  assign w_done_vec = r_owner ? 2'b10 : 2'b01;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_owner    <= 1'b0;
      r_last     <= 1'b1;
      r_timer    <= '0;
      r_cmd      <= '0;
      r_data     <= '0;
      r_send     <= 1'b0;
      r_clr      <= 1'b0;
      r_done     <= '0;
      r_resp_out <= '0;
      r_ack      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (|w_pend) begin
            r_state <= SEND;
            r_owner <= w_gnt;
            r_cmd   <= w_word[w_gnt].cmd;
            r_data  <= w_word[w_gnt].data;
            r_send  <= 1'b1;
            r_clr   <= 1'b1;
          end
        end
        SEND: begin
          r_send  <= 1'b0;
          r_clr   <= 1'b0;
          r_state <= WAIT_SENT;
        end
        WAIT_SENT: begin
          if (cmd_sent) begin
            r_state <= WAIT_RESP;
            r_timer <= '0;
          end
        end
        WAIT_RESP: begin
          // A response in the expiry cycle still counts as a response.
          if (resp_rdy) begin
            r_state    <= DONE;
            r_done     <= w_done_vec;
            r_clr      <= 1'b1;
            r_resp_out <= resp;
            r_ack      <= (resp == ACK_POS);
            r_tmo      <= 1'b0;
          end else if (r_timer == L_LAST) begin
            r_state    <= DONE;
            r_done     <= w_done_vec;
            r_clr      <= 1'b1;
            r_resp_out <= '0;
            r_ack      <= 1'b0;
            r_tmo      <= 1'b1;
          end else begin
            r_timer <= r_timer + 1'b1;
          end
        end
        DONE: begin
          r_done  <= '0;
          r_clr   <= 1'b0;
          r_last  <= r_owner;
          r_state <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign rdy          = w_rdy;
  assign done         = r_done;
  assign resp_out     = r_resp_out;
  assign ack_ok       = r_ack;
  assign timeout      = r_tmo;
  assign send_cmd     = r_send;
  assign cmd          = r_cmd;
  assign data         = r_data;
  assign clr_resp_rdy = r_clr;

endmodule

// File: tb/tb_remote_cmd_arbiter.sv
// tb_remote_cmd_arbiter: randomized scoreboard bench for the arbiter.
// RemoteComm responder model plus a cycle model of the slot/grant rules.
module tb_remote_cmd_arbiter;

  localparam int T = 16;
  localparam logic [7:0] ACK = 8'hA5;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  req = '0;
  logic [7:0]  cmd0 = '0, cmd1 = '0;
  logic [15:0] data0 = '0, data1 = '0;
  logic [1:0]  rdy, done;
  logic [7:0]  resp_out;
  logic        ack_ok, timeout, send_cmd;
  logic [7:0]  cmd;
  logic [15:0] data;
  logic        cmd_sent = 1'b0;
  logic        resp_rdy;
  logic [7:0]  resp = '0;
  logic        clr_resp_rdy;
  logic        raise = 1'b0;
  logic        stale_raise = 1'b0;

  remote_cmd_arbiter #(.TMO_W(20), .TIMEOUT_CYC(20'd16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req          (req),
    .cmd0         (cmd0),
    .cmd1         (cmd1),
    .data0        (data0),
    .data1        (data1),
    .rdy          (rdy),
    .done         (done),
    .resp_out     (resp_out),
    .ack_ok       (ack_ok),
    .timeout      (timeout),
    .send_cmd     (send_cmd),
    .cmd          (cmd),
    .data         (data),
    .cmd_sent     (cmd_sent),
    .resp_rdy     (resp_rdy),
    .resp         (resp),
    .clr_resp_rdy (clr_resp_rdy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RemoteComm response flag: set by a new response, cleared by clr.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    resp_rdy <= 1'b0;
    else if (clr_resp_rdy)         resp_rdy <= 1'b0;
    else if (raise || stale_raise) resp_rdy <= 1'b1;
  end

  typedef struct {
    logic [7:0] r;
    logic       a;
    logic       t;
    int         lat;
  } exp_t;

  exp_t sb[$];
  int   order[$];

  int n_checks = 0;
  int n_errors = 0;

  logic [1:0]  m_pend;
  int          m_last;
  logic        m_idle, m_busy, exp_send;
  int          m_owner;
  logic [7:0]  m_c [2];
  logic [15:0] m_d [2];
  logic [7:0]  m_gc;
  logic [15:0] m_gd;
  logic [7:0]  m_ro;
  logic        m_ao, m_to;
  int          m_sent_cyc = 0;
  logic        resp_busy = 1'b0;
  int          dir_k = -1;
  int          dir_resp = -1;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               nm, act, exp, cyc);
    end
  endtask

  // RemoteComm responder: picks delays per command, posts expectation.
  initial begin
    int ds, kk;
    logic [7:0] rv;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n && send_cmd) begin
        resp_busy = 1'b1;
        ds = $urandom_range(1, 3);
        if (dir_k >= 0) kk = dir_k;
        else if ($urandom_range(0, 4) == 0) kk = 0;
        else kk = $urandom_range(1, T + 2);
        if (dir_resp >= 0) rv = 8'(dir_resp);
        else if ($urandom_range(0, 1) == 1) rv = ACK;
        else rv = 8'($urandom);
        // resp_rdy is high kk cycles after the cmd_sent cycle.
        if (kk >= 1 && kk <= T) begin
          e.r = rv; e.a = (rv == ACK); e.t = 1'b0; e.lat = kk + 1;
        end else begin
          e.r = 8'h00; e.a = 1'b0; e.t = 1'b1; e.lat = T + 1;
        end
        sb.push_back(e);
        repeat (ds) @(posedge clk);
        #1;
        cmd_sent = 1'b1;
        m_sent_cyc = cyc;
        if (kk == 1) begin raise = 1'b1; resp = rv; end
        @(posedge clk);
        #1;
        cmd_sent = 1'b0;
        raise = 1'b0;
        if (kk >= 2) begin
          repeat (kk - 2) begin @(posedge clk); #1; end
          raise = 1'b1;
          resp = rv;
          @(posedge clk);
          #1;
          raise = 1'b0;
        end
        resp_busy = 1'b0;
      end
    end
  end

  // Reference model and monitor, evaluated mid-cycle.
  initial begin
    exp_t e;
    logic [1:0] exp_rdy;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        chk("rst_rdy", rdy, 2'b11);
        chk("rst_send_cmd", send_cmd, 0);
        chk("rst_clr_resp_rdy", clr_resp_rdy, 0);
        chk("rst_done", done, 0);
        chk("rst_resp_out", resp_out, 0);
        chk("rst_ack_ok", ack_ok, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_cmd", cmd, 0);
        chk("rst_data", data, 0);
        m_pend = '0; m_last = 1; m_idle = 1'b1; m_busy = 1'b0;
        exp_send = 1'b0; sb.delete();
        m_ro = '0; m_ao = 1'b0; m_to = 1'b0;
      end else begin
        exp_rdy = ~m_pend;
        chk("rdy", rdy, exp_rdy);
        chk("send_cmd", send_cmd, exp_send);
        chk("clr_resp_rdy", clr_resp_rdy, exp_send || (done != 0));
        if (m_busy) begin
          chk("cmd", cmd, m_gc);
          chk("data", data, m_gd);
        end
        exp_send = 1'b0;
        if (done != 0) begin
          if (!m_busy || sb.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_done: got %b expected 00 at cycle %0d",
                     done, cyc);
          end else begin
            e = sb.pop_front();
            chk("done_owner", done, (m_owner == 1) ? 2'b10 : 2'b01);
            chk("done_latency", cyc - m_sent_cyc, e.lat);
            m_ro = e.r; m_ao = e.a; m_to = e.t;
            order.push_back(done[1] ? 1 : 0);
          end
        end
        chk("resp_out", resp_out, m_ro);
        chk("ack_ok", ack_ok, m_ao);
        chk("timeout", timeout, m_to);
        if (m_idle && m_pend != 0) begin
          if (m_pend == 2'b11) m_owner = 1 - m_last;
          else m_owner = m_pend[1] ? 1 : 0;
          m_gc = m_c[m_owner];
          m_gd = m_d[m_owner];
          m_idle = 1'b0;
          m_busy = 1'b1;
          exp_send = 1'b1;
        end
        if (req[0] && !m_pend[0]) begin
          m_pend[0] = 1'b1; m_c[0] = cmd0; m_d[0] = data0;
        end
        if (req[1] && !m_pend[1]) begin
          m_pend[1] = 1'b1; m_c[1] = cmd1; m_d[1] = data1;
        end
        if (done != 0 && m_busy) begin
          m_pend[m_owner] = 1'b0;
          m_last = m_owner;
          m_idle = 1'b1;
          m_busy = 1'b0;
        end
      end
    end
  end

  task automatic pulse(input logic [1:0] r, input logic [7:0] c0,
                       input logic [15:0] d0, input logic [7:0] c1,
                       input logic [15:0] d1);
    @(posedge clk);
    #1;
    req = r; cmd0 = c0; data0 = d0; cmd1 = c1; data1 = d1;
    @(posedge clk);
    #1;
    req = '0;
  endtask

  task automatic drain(input int lim);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      @(negedge clk);
      if (m_idle && m_pend == 0 && sb.size() == 0 && !resp_busy &&
          !exp_send) begin
        ok = 1'b1;
        break;
      end
    end
    n_checks++;
    if (!ok) begin
      n_errors++;
      $display("FAIL drain: still busy after %0d cycles, expected idle",
               lim);
    end
  endtask

  initial begin
    bit seen;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Ties: slot 0 first after reset, then strict alternation.
    order.delete();
    pulse(2'b11, 8'h11, 16'h0101, 8'h21, 16'h0202);
    drain(200);
    pulse(2'b11, 8'h12, 16'h0303, 8'h22, 16'h0404);
    drain(200);
    chk("tie_count", order.size(), 4);
    for (int i = 0; i < order.size() && i < 4; i++)
      chk("tie_order", order[i], i % 2);

    // Single request with ACK, plus a dropped request while busy.
    dir_k = 3; dir_resp = 8'hA5;
    pulse(2'b01, 8'h05, 16'h1234, 8'h00, 16'h0000);
    pulse(2'b01, 8'h07, 16'h5678, 8'h00, 16'h0000);
    drain(200);

    // Plain timeout.
    dir_k = 0; dir_resp = -1;
    pulse(2'b10, 8'h00, 16'h0000, 8'h33, 16'hCAFE);
    drain(200);

    // Response lands in the expiry cycle.
    dir_k = T; dir_resp = 8'hFF;
    pulse(2'b01, 8'h44, 16'h4444, 8'h00, 16'h0000);
    drain(200);

    // Stale response before SEND must be flushed.
    dir_k = 0; dir_resp = -1;
    @(posedge clk); #1 stale_raise = 1'b1;
    @(posedge clk); #1 stale_raise = 1'b0;
    pulse(2'b10, 8'h00, 16'h0000, 8'h55, 16'h5555);
    drain(200);

    // Randomized traffic.
    dir_k = -1; dir_resp = -1;
    for (int i = 0; i < 800; i++) begin
      @(posedge clk);
      #1;
      req[0] = ($urandom_range(0, 4) == 0);
      req[1] = ($urandom_range(0, 4) == 0);
      cmd0 = 8'($urandom); cmd1 = 8'($urandom);
      data0 = 16'($urandom); data1 = 16'($urandom);
    end
    @(posedge clk); #1 req = '0;
    drain(500);

    // Reset in the middle of WAIT_RESP.
    dir_k = 0;
    pulse(2'b10, 8'h00, 16'h0000, 8'h66, 16'h6666);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_sent) begin seen = 1'b1; break; end
    end
    chk("cmd_sent_seen", seen, 1);
    repeat (4) @(posedge clk);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    dir_k = 2; dir_resp = 8'hA5;
    pulse(2'b01, 8'h3C, 16'hBEEF, 8'h00, 16'h0000);
    drain(200);

    $display("Simulation finished: %0d checks, %0d errors",
             n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/remote_cmd_arbiter.md
# remote_cmd_arbiter

Shares one RemoteComm transceiver between two independent command sources (e.g. the scripted test sequencer and a periodic heartbeat generator). It buffers one request per source, grants round-robin, drives RemoteComm's send_cmd/cmd/data, waits for cmd_sent and then for the 8-bit response, and returns the response or a timeout to the owning requester. It sits directly above RemoteComm; all RemoteComm handshakes pass through this block.

## Interface
- TIMEOUT_CYC, default 20'd1_000_000: cycles allowed from cmd_sent to resp_rdy before a timeout is declared; must be ≥ 2.
- TMO_W, default 20: timer width; must satisfy TIMEOUT_CYC < 2^TMO_W.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- req  in  2  per-requester one-cycle request pulse.
- cmd0, cmd1  in  8  command byte, sampled with req[i].
- data0, data1  in  16  data word, sampled with req[i].
- rdy  out  2  rdy[i]=1 means slot i is empty and accepts req[i].
- done  out  2  one-cycle completion pulse to the owner.
- resp_out  out  8  response byte, valid with done.
- ack_ok  out  1  resp_out == ACK_POS, valid with done.
- timeout  out  1  completion was a timeout, valid with done.
- send_cmd  out  1  to RemoteComm.
- cmd  out  8  to RemoteComm.
- data  out  16  to RemoteComm.
- cmd_sent  in  1  from RemoteComm.
- resp_rdy  in  1  from RemoteComm.
- resp  in  8  from RemoteComm.
- clr_resp_rdy  out  1  to RemoteComm.

## Operation
- Slots: req[i] with rdy[i]=1 latches cmd_i and data_i into slot i and sets pending[i]. req[i] with rdy[i]=0 is ignored and the slot is unchanged. rdy[i] = ~pending[i].
- Arbitration in IDLE: one pending slot is granted directly. With both pending, the slot not served last wins. last_gnt resets to 1, so slot 0 wins the first tie.
- Grant copies the slot into the cmd/data output registers. cmd and data are held stable from SEND through DONE, because RemoteComm reads cmd live during transmission.
- FSM states:
  - IDLE: any pending → SEND.
  - SEND: single cycle. send_cmd=1 and clr_resp_rdy=1, which flushes any stale response. → WAIT_SENT.
  - WAIT_SENT: resp_rdy is ignored. cmd_sent → WAIT_RESP, timer cleared to 0.
  - WAIT_RESP: timer increments each cycle. resp_rdy → DONE with resp captured. Timer == TIMEOUT_CYC-1 without resp_rdy → DONE with timeout.
  - DONE: single cycle. Asserts done[owner], clr_resp_rdy=1 and the result outputs. Clears pending[owner] and updates last_gnt. → IDLE.
- Simultaneous events:
  - resp_rdy in the same cycle as timer expiry: the response wins, timeout=0.
  - req[owner] in the DONE cycle: ignored, since rdy is still 0 in that cycle.
- Result outputs:
  - Response: resp_out=resp, ack_ok=(resp==ACK_POS), timeout=0.
  - Timeout: resp_out=8'h00, ack_ok=0, timeout=1.
  - All three are registered and hold their values until the next DONE.
- Reset: rst_n low at any point aborts any transaction, with no done pulse. Reset values:
  - State IDLE, pending=0 (rdy=2'b11), last_gnt=1.
  - send_cmd, clr_resp_rdy, done, ack_ok, timeout = 0.
  - resp_out, cmd, data = 0.

## Timing
- All outputs are registered Moore outputs of state and data registers. rdy is decoded from the pending flops.
- Idle latency: req[i] in cycle N → pending at edge N+1 → send_cmd high in cycle N+2.
- cmd_sent in cycle M → WAIT_RESP from M+1. resp_rdy in cycle R → done and clr_resp_rdy high in cycle R+1 → IDLE at R+2.
- Timeout: done occurs TIMEOUT_CYC+1 cycles after the cmd_sent cycle.
- Back-to-back: a pending other slot reaches SEND 2 cycles after DONE, via IDLE.

## Structure
- Shared package (remote_pkg): ACK_POS = 8'hA5 and the arbiter state enum typedef (IDLE, SEND, WAIT_SENT, WAIT_RESP, DONE). RemoteComm-side code uses the same package.
- One sub-module, req_slot: the per-requester holding register with pending/rdy. It is instantiated twice. The FSM, arbiter and timer stay in the top level.

## Test plan
- Single request: req[0] with cmd0=8'h05 and data0=16'h1234; the RemoteComm model returns 8'hA5 → send_cmd in cycle N+2 with cmd=05 and data=1234; then done=2'b01, resp_out=A5, ack_ok=1, timeout=0.
- Tie: req=2'b11 in the same cycle → slot 0 is served first, then slot 1. Re-arm both, and slot 1 wins the next tie only if slot 0 was served last. Verify the strict alternation 0,1,0,1.
- Timeout: TIMEOUT_CYC=16, with no response after cmd_sent → done exactly 17 cycles after cmd_sent, timeout=1, resp_out=00. Slot freed: rdy[i]=1 in the cycle after done.
- Busy drop: a second req[0] with cmd0=8'h07 while rdy[0]=0 → ignored; only cmd 05 is ever sent.
- Response/expiry collision: resp_rdy asserted with resp=8'hFF in the expiry cycle → timeout=0, resp_out=FF, ack_ok=0. Also check that a stale resp_rdy before SEND is cleared by the clr_resp_rdy pulse in SEND.
- Reset mid-WAIT_RESP → all outputs at reset values, no done pulse, rdy=2'b11. A new request then completes normally.
